// File: rtl/agu_conv_gen.sv
// Convolution address generator: latches a job on start_conv, then walks index slots x trips,
// emitting one buffer-read descriptor per accepted beat and pulsing done when the walk completes.
module agu_conv_gen #(
  parameter int ADDR_W = 12,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_conv,
  input  logic [IDX_W-1:0]  conf_idx_cnt,
  input  logic [7:0]        conf_trip_cnt,
  input  logic              conf_is_new,
  input  logic              conf_pad_l,
  input  logic [5:0]        conf_lim_r,
  input  logic [5:0]        conf_row_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_half,
  output logic              out_pad_l,
  output logic              out_pad_r,
  output logic              out_acc_clr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  cfg_idx_cnt_r;
  logic [7:0]        trip_r;
  logic [7:0]        cfg_trip_cnt_r;
  logic [ADDR_W-1:0] row_base_r;
  logic              cfg_is_new_r;
  logic              cfg_pad_l_r;
  logic [5:0]        cfg_lim_r;
  logic [5:0]        cfg_row_cnt_r;

  logic run_s;
  logic trip_end_s;
  logic idx_end_s;
  logic zero_job_s;

  assign run_s      = (state_r == ST_RUN);
  assign trip_end_s = (trip_r == (cfg_trip_cnt_r - 8'd1));
  assign idx_end_s  = (idx_r == (cfg_idx_cnt_r - IDX_ONE));
  assign zero_job_s = (conf_idx_cnt == {IDX_W{1'b0}}) | (conf_trip_cnt == 8'd0);

  // Job sequencing: config capture, index/trip walk and state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      idx_r          <= {IDX_W{1'b0}};
      trip_r         <= 8'd0;
      row_base_r     <= {ADDR_W{1'b0}};
      cfg_idx_cnt_r  <= {IDX_W{1'b0}};
      cfg_trip_cnt_r <= 8'd0;
      cfg_is_new_r   <= 1'b0;
      cfg_pad_l_r    <= 1'b0;
      cfg_lim_r      <= 6'd0;
      cfg_row_cnt_r  <= 6'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_conv) begin
            cfg_idx_cnt_r  <= conf_idx_cnt;
            cfg_trip_cnt_r <= conf_trip_cnt;
            cfg_is_new_r   <= conf_is_new;
            cfg_pad_l_r    <= conf_pad_l;
            cfg_lim_r      <= conf_lim_r;
            cfg_row_cnt_r  <= conf_row_cnt;
            idx_r          <= {IDX_W{1'b0}};
            trip_r         <= 8'd0;
            row_base_r     <= {ADDR_W{1'b0}};
            state_r        <= zero_job_s ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            if (trip_end_s) begin
              trip_r     <= 8'd0;
              idx_r      <= idx_r + IDX_ONE;
              row_base_r <= row_base_r + {{(ADDR_W-6){1'b0}}, cfg_row_cnt_r};
              if (idx_end_s) begin
                state_r <= ST_DONE;
              end
            end else begin
              trip_r <= trip_r + 8'd1;
            end
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE);
  assign done = (state_r == ST_DONE);

  // Descriptor decode from registered walk state; fields are held at zero outside RUN
  always_comb begin
    out_valid   = 1'b0;
    out_idx     = {IDX_W{1'b0}};
    out_addr    = {ADDR_W{1'b0}};
    out_half    = 1'b0;
    out_pad_l   = 1'b0;
    out_pad_r   = 1'b0;
    out_acc_clr = 1'b0;
    out_last    = 1'b0;
    if (run_s) begin
      out_valid   = 1'b1;
      out_idx     = idx_r;
      out_addr    = row_base_r + {{(ADDR_W-7){1'b0}}, trip_r[7:1]};
      out_half    = trip_r[0];
      out_pad_l   = cfg_pad_l_r & (trip_r == 8'd0);
      out_pad_r   = (trip_r >= {2'b00, cfg_lim_r});
      out_acc_clr = cfg_is_new_r & (idx_r == {IDX_W{1'b0}});
      out_last    = idx_end_s & trip_end_s;
    end else begin
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_agu_conv_gen.sv
// Scoreboard bench for agu_conv_gen: directed jobs push expected descriptors,
// a negedge monitor pops and compares each accepted beat and checks stall stability.
module tb_agu_conv_gen;
  localparam int ADDR_W = 12;
  localparam int IDX_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_conv;
  logic [IDX_W-1:0]  conf_idx_cnt;
  logic [7:0]        conf_trip_cnt;
  logic              conf_is_new;
  logic              conf_pad_l;
  logic [5:0]        conf_lim_r;
  logic [5:0]        conf_row_cnt;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [ADDR_W-1:0] out_addr;
  logic              out_half;
  logic              out_pad_l;
  logic              out_pad_r;
  logic              out_acc_clr;
  logic              out_last;
  logic              busy;
  logic              done;

  agu_conv_gen #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv),
    .conf_idx_cnt(conf_idx_cnt), .conf_trip_cnt(conf_trip_cnt), .conf_is_new(conf_is_new),
    .conf_pad_l(conf_pad_l), .conf_lim_r(conf_lim_r), .conf_row_cnt(conf_row_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_addr(out_addr),
    .out_half(out_half), .out_pad_l(out_pad_l), .out_pad_r(out_pad_r),
    .out_acc_clr(out_acc_clr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  idx;
    logic [11:0] addr;
    logic        half;
    logic        pad_l;
    logic        pad_r;
    logic        acc_clr;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs;
  beat_t held;
  beat_t exp_b;
  bit    held_v = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_fire_cyc = -10;
  logic [3:0] bp_pat = 4'b1001;

  assign obs = {out_idx, out_addr, out_half, out_pad_l, out_pad_r, out_acc_clr, out_last};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every accepted beat against the scoreboard, and stalled beats against the held copy
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held_v) check("stall_stable", 32'(obs), 32'(held));
      if (out_ready) begin
        held_v = 1'b0;
        last_fire_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got beat 0x%0h, expected no beat", obs);
        end else begin
          exp_b = exp_q.pop_front();
          check("beat", 32'(obs), 32'(exp_b));
        end
      end else begin
        held   = obs;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic push(input int idx, input int addr, input int half, input int pl,
                      input int pr, input int ac, input int last);
    exp_q.push_back({8'(idx), 12'(addr), 1'(half), 1'(pl), 1'(pr), 1'(ac), 1'(last)});
  endtask

  task automatic set_conf(input int idx, input int trip, input int is_new, input int pad_l,
                          input int lim, input int row);
    conf_idx_cnt  = 8'(idx);
    conf_trip_cnt = 8'(trip);
    conf_is_new   = 1'(is_new);
    conf_pad_l    = 1'(pad_l);
    conf_lim_r    = 6'(lim);
    conf_row_cnt  = 6'(row);
  endtask

  // idx_cnt=2, trip_cnt=3, row_cnt=2, lim_r=4, no pad, not new
  task automatic basic_exp();
    push(0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0, 0);
    push(1, 2, 0, 0, 0, 0, 0);
    push(1, 2, 1, 0, 0, 0, 0);
    push(1, 3, 0, 0, 0, 0, 1);
  endtask

  // idx_cnt=2, trip_cnt=4, row_cnt=2, lim_r=3, pad_l, is_new
  task automatic pad_exp();
    push(0, 0, 0, 1, 0, 1, 0);
    push(0, 0, 1, 0, 0, 1, 0);
    push(0, 1, 0, 0, 0, 1, 0);
    push(0, 1, 1, 0, 1, 1, 0);
    push(1, 2, 0, 1, 0, 0, 0);
    push(1, 2, 1, 0, 0, 0, 0);
    push(1, 3, 0, 0, 0, 0, 0);
    push(1, 3, 1, 0, 1, 0, 1);
  endtask

  // Called #1 after a clock edge with the DUT idle; leaves time #1 after the sampling edge
  task automatic start_job(input bit exp_valid);
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
    check("first_valid", 32'(out_valid), 32'(exp_valid));
    check("busy_run", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input bit bp, input bit zero_job);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (bp) out_ready = bp_pat[i % 4];
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 200 cycles, expected done");
    end else begin
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (!zero_job) check("done_latency", 32'(cyc), 32'(last_fire_cyc + 1));
      check("done_no_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_conv = 1'b0;
    out_ready = 1'b1;
    set_conf(0, 0, 0, 0, 0, 0);
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fields", 32'(obs), 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // basic walk
    set_conf(2, 3, 0, 0, 4, 2);
    basic_exp();
    start_job(1'b1);
    wait_done(1'b0, 1'b0);

    // padding / accumulator clear
    set_conf(2, 4, 1, 1, 3, 2);
    pad_exp();
    start_job(1'b1);
    wait_done(1'b0, 1'b0);

    // backpressure
    set_conf(2, 3, 0, 0, 4, 2);
    basic_exp();
    start_job(1'b1);
    wait_done(1'b1, 1'b0);

    // zero index count, then zero trip count
    set_conf(0, 3, 0, 0, 4, 2);
    start_job(1'b0);
    check("zero_idx_done", 32'(done), 32'd1);
    wait_done(1'b0, 1'b1);
    set_conf(2, 0, 0, 0, 4, 2);
    start_job(1'b0);
    check("zero_trip_done", 32'(done), 32'd1);
    wait_done(1'b0, 1'b1);

    // start ignored mid-job, then back-to-back restart
    set_conf(2, 3, 0, 0, 4, 2);
    basic_exp();
    start_job(1'b1);
    @(posedge clk); #1;
    set_conf(5, 7, 1, 1, 0, 9);
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
    wait_done(1'b0, 1'b0);
    set_conf(2, 4, 1, 1, 3, 2);
    pad_exp();
    start_job(1'b1);
    wait_done(1'b0, 1'b0);

    // async reset mid-job at idx 1, trip 2
    set_conf(2, 4, 1, 1, 3, 2);
    pad_exp();
    start_job(1'b1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("pre_rst_idx", 32'(out_idx), 32'd1);
    check("pre_rst_addr", 32'(out_addr), 32'd3);
    check("pre_rst_half", 32'(out_half), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    set_conf(2, 3, 0, 0, 4, 2);
    basic_exp();
    start_job(1'b1);
    wait_done(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/agu_conv_gen.md
Name: agu_conv_gen

Overview:
- Consumer end of the AGU configuration interface.
- Waits for the one-cycle start_conv pulse, then captures the registered conf_* fields.
- Walks idx_cnt index slots × trip_cnt trips, emitting one buffer-read descriptor per beat on a valid/ready stream toward the PE buffer read port.
- Signals completion with a one-cycle done pulse. Sits directly downstream of the configuration register block, in parallel with the FC generator.

Parameters:
ADDR_W, 12, width of generated buffer address (arithmetic wraps modulo 2^ADDR_W)
IDX_W, 8, width of index count/counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
start_conv  in  1  one-cycle start pulse from config block
conf_idx_cnt  in  IDX_W  number of index slots
conf_trip_cnt  in  8  trips per index slot
conf_is_new  in  1  first pass; accumulator must be cleared
conf_pad_l  in  1  left padding present
conf_lim_r  in  6  right limit; trips at or beyond it are padded
conf_row_cnt  in  6  buffer rows per index slot (= ceil(trip_cnt/2))
out_valid  out  1  descriptor valid
out_ready  in  1  downstream accepts descriptor
out_idx  out  IDX_W  current index slot
out_addr  out  ADDR_W  buffer row address
out_half  out  1  low/high half of row (trip LSB)
out_pad_l  out  1  beat is left-pad position
out_pad_r  out  1  beat is right-pad position
out_acc_clr  out  1  downstream clears accumulator for this beat
out_last  out  1  final beat of the job
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- Reset: state IDLE; all counters and latched config 0; out_valid, out_* fields, busy, done all 0. Asserting rst mid-job aborts immediately, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_conv=1 latches all conf_* fields into internal registers and clears idx_r, trip_r, row_base.
  - Next state is RUN, or DONE if conf_idx_cnt==0 or conf_trip_cnt==0.
  - start_conv is ignored in RUN and DONE (no relatch, no effect).
- Config capture: start_conv occurs one cycle after the config block registers conf_*, so conf_* are sampled in the same cycle as start_conv.
- RUN:
  - busy=1, out_valid=1.
  - All out_* fields are functions of registered state only and must hold stable while out_valid & !out_ready.
- Beat fires on out_valid & out_ready. On fire:
  - If trip_r == trip_cnt-1: trip_r<=0, idx_r<=idx_r+1, row_base<=row_base+row_cnt (mod 2^ADDR_W). Otherwise trip_r<=trip_r+1.
  - If the final beat fires (idx_r==idx_cnt-1 and trip_r==trip_cnt-1), next state is DONE.
- Field definitions:
  - out_idx = idx_r
  - out_addr = row_base + {0, trip_r[7:1]} (mod 2^ADDR_W)
  - out_half = trip_r[0]
  - out_pad_l = pad_l & (trip_r==0)
  - out_pad_r = (trip_r >= {2'b00, lim_r})
  - out_acc_clr = is_new & (idx_r==0)
  - out_last = (idx_r==idx_cnt-1) & (trip_r==trip_cnt-1)
- DONE: out_valid=0, busy=1, done=1 for exactly one cycle, then IDLE with busy=0.
- Latency:
  - start_conv in cycle 0 → first out_valid in cycle 1.
  - Final fire in cycle N → done=1 in cycle N+1 → IDLE in cycle N+2, where a new start_conv is accepted.
- Throughput: one beat per cycle with out_ready held high. Job length is exactly idx_cnt*trip_cnt beats.
- Zero-count jobs: zero beats; done in cycle 1.
- Widths: trip_r is 8 bit; lim_r is zero-extended for comparison. lim_r > trip_cnt-1 means no right pad (e.g. lim_r=trip_cnt+1). lim_r=0 pads all trips.

Test Plan:
- Basic walk: idx_cnt=2, trip_cnt=3, row_cnt=2, pad_l=0, lim_r=4, is_new=0, out_ready=1 → exactly 6 beats:
  - (idx, addr, half) = (0,0,0), (0,0,1), (0,1,0), (1,2,0), (1,2,1), (1,3,0).
  - out_last only on the 6th beat; done one cycle later.
- Padding/clear: idx_cnt=2, trip_cnt=4, pad_l=1, lim_r=3, is_new=1:
  - out_pad_l on trip 0 of each idx.
  - out_pad_r on trip 3 only.
  - out_acc_clr on idx 0 beats (4 beats) only.
- Backpressure: basic walk with out_ready toggling 1,0,0,1,... → all fields stable during stalls, same 6-beat sequence, no duplicated or dropped beats.
- Zero count: start_conv with idx_cnt=0 → out_valid never high; done=1 in cycle 1, busy=0 in cycle 2. Repeat with trip_cnt=0 → identical response.
- Ignored start / restart: start_conv pulsed mid-job with different conf → original sequence unaffected. A new start_conv in the cycle after done is accepted; the first beat of the new job arrives in the next cycle.
- Async reset: assert rst between clock edges mid-job (idx 1, trip 2) → out_valid, busy, done drop to 0 without waiting for an edge. After release, no done pulse occurs and a fresh job runs from idx 0.
